// File: rtl/vpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Fetch entries pair the instruction with its address.
package vpu_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; flush overrides push and pop.
// Read data is the registered head entry, no write-through bypass.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (cnt_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: issues PC fetches, buffers responses,
// hands them to decode, and discards stale responses after a redirect.
module instr_fetch_unit #(
  parameter int XLEN        = vpu_fetch_pkg::XLEN,
  parameter int DEPTH       = 4,
  parameter int INSTR_BYTES = vpu_fetch_pkg::INSTR_BYTES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready
);

  import vpu_fetch_pkg::*;

  localparam int          CW  = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  localparam int          EW  = $bits(fetch_entry_t);

  fetch_state_e  state_q, state_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] aq_cnt;
  logic [CW-1:0] outst;
  logic [CW:0]   used;
  logic [XLEN-1:0] aq_pc;
  logic          req_fire;
  logic          keep_rsp;
  logic          if_pop;
  fetch_entry_t  ent_in;
  fetch_entry_t  ent_out;

  // Stale responses are counted in drop_q, live ones sit in the
  // address queue, so together they are the outstanding count.
  assign outst = aq_cnt + drop_q;
  assign used  = {1'b0, fifo_cnt} + {1'b0, outst};

  assign imem_req_valid = ~reset & fetch_en & ~redirect
                        & (used < CAP);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  always_comb begin
    pc_next = pc;
    unique case (1'b1)
      redirect: pc_next = redirect_pc;
      req_fire: pc_next = pc + XLEN'(INSTR_BYTES);
      default:  pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    unique case (1'b1)
      redirect: begin
        drop_d  = outst - CW'(imem_rsp_valid);
        state_d = (drop_d != '0) ? DRAIN : RUN;
      end
      (!redirect && state_q == DRAIN && imem_rsp_valid): begin
        drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
    keep_rsp = 1'b0;
    if (state_q == RUN) keep_rsp = imem_rsp_valid & ~redirect;
  end

  assign ent_in.pc    = aq_pc;
  assign ent_in.instr = imem_rsp_data;

  assign if_valid = (fifo_cnt != '0);
  assign if_pop   = if_valid & if_ready;
  assign if_pc    = ent_out.pc;
  assign if_instr = ent_out.instr;

  fetch_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_addr_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_fire),
    .pop_i   (keep_rsp),
    .flush_i (redirect),
    .din_i   (pc),
    .dout_o  (aq_pc),
    .count_o (aq_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_instr_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (keep_rsp),
    .pop_i   (if_pop),
    .flush_i (redirect),
    .din_i   (ent_in),
    .dout_o  (ent_out),
    .count_o (fifo_cnt)
  );

endmodule
